track_select_ctrl: RTL and testbench
====================================

// Module: track_select_ctrl
// PURPOSE
//   Upstream control stage for the 7-segment time/track display.
//   - Debounces the raw PREV/NEXT push-buttons and turns each press into a single-cycle prev/next pulse.
//   - Advances automatically on song_done.
//   - Keeps the current track index, and drives it both as a binary value (audio source select)
//     and as two BCD digits for the display (tens and ones of the 1-based track number).
// PARAMETERS
//   NUM_TRACKS       12     number of tracks, 2..99; index range 0..NUM_TRACKS-1
//   DEBOUNCE_CYCLES  20000  consecutive stable cycles needed to accept a level change (>=2)
//   CNT_W            15     debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//   clk          in   1  system clock (1 MHz in the player); the only clock
//   rst          in   1  synchronous, active-high reset
//   btn_prev_raw in   1  raw PREV button, asynchronous, active-high, bouncy
//   btn_next_raw in   1  raw NEXT button, asynchronous, active-high, bouncy
//   song_done    in   1  1-cycle pulse: current track finished playing
//   prev         out  1  1-cycle pulse: track changed backwards (clears the display timer)
//   next         out  1  1-cycle pulse: track changed forwards (clears the display timer)
//   track_idx    out  7  current track index, binary, 0-based
//   trk_ones     out  4  BCD ones digit of (track_idx+1)
//   trk_tens     out  4  BCD tens digit of (track_idx+1)
// BEHAVIOUR
//   Reset (rst=1 at an edge; applies to all state and outputs):
//     - prev=0, next=0, track_idx=0, trk_ones=1, trk_tens=0.
//     - Synchronisers, debounced levels and previous-level registers = 0; debounce counters = 0.
//     - Reset mid-debounce or mid-press discards all progress.
//     - A button still held after reset is released is not a press. The debounced level first
//       rises to 1 with no pulse, because the edge detector is cleared to 0 only on a
//       debounced 0->1 transition that happens after a debounced low.
//   Synchroniser: each raw input passes through a 2-flop synchroniser (s1 -> s2).
//   Debounce, per button, using s2, debounced level db and counter cnt:
//     - s2 == db: cnt <= 0.
//     - s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
//     - Otherwise: cnt <= cnt+1.
//     - Any glitch back to db before the limit restarts the count.
//   Edge detect: press = db & ~db_d, where db_d is db delayed one cycle. A release produces no pulse.
//   Latency: raw held constant from edge N -> db rises at edge N+DEBOUNCE_CYCLES+1;
//     the prev/next pulse and the track update both occur at edge N+DEBOUNCE_CYCLES+2.
//   Event arbitration, using cycle-level requests p (prev press), n (next press), d (song_done):
//     - p & n: both ignored; no pulse, no change (d is ignored too).
//     - p only: backward step (d ignored).
//     - n only, d only, or n & d: a single forward step.
//   Step rules, registered on the same edge as the pulse:
//     - Forward: track_idx==NUM_TRACKS-1 -> 0, digits 0/1. Otherwise idx+1, and the BCD value
//       increments (ones 9 -> 0 with tens+1).
//     - Backward: track_idx==0 -> NUM_TRACKS-1, digits = BCD(NUM_TRACKS). Otherwise idx-1, and the
//       BCD value decrements (ones 0 -> 9 with tens-1).
//     - BCD is kept by separate counters, not by division, and must always equal track_idx+1.
//   Pulses: prev/next are high for exactly one cycle per accepted step and never high together.
//     next is also asserted for a song_done step.
//   A held button gives exactly one step per press, however long it is held.
// TESTING (NUM_TRACKS=12, DEBOUNCE_CYCLES=4 on the bench)
//   1. Reset, then idle 20 cycles -> prev=next=0, track_idx=0, tens/ones=0/1.
//   2. NEXT raw toggles 1,0,1,0, then held high 30 cycles -> one next pulse, 6 cycles after the
//      stable rise; idx=1, digits 0/2; no more pulses while held.
//   3. From idx 0, one PREV press -> prev pulse; idx=11, digits 1/2. A following NEXT press -> idx=0, digits 0/1.
//   4. Nine NEXT presses from 0 -> idx=9, digits 1/0 (BCD carry). Then one PREV -> idx=8, digits 0/9 (borrow).
//   5. PREV and NEXT raw rise on the same edge -> no pulse, idx unchanged. song_done alone -> next pulse, idx+1.
//      song_done in the same cycle as a prev press -> prev wins, single step back.
//   6. rst asserted 2 cycles into a NEXT debounce, released with the button still held
//      -> no pulse, idx=0. Release then press again -> one next pulse.

Source files
------------

// File: rtl/track_select_ctrl.sv
// ---------------------------------------------------------------------------
// track_select_ctrl
//
// Upstream control stage for the 7-segment time/track display. Debounces the
// raw PREV/NEXT buttons, turns each press into one prev/next pulse, advances
// automatically on song_done, and holds the current track both as a binary
// index and as two BCD digits of the 1-based track number.
//
// Ports
//   clk           in   system clock, the only clock
//   rst           in   synchronous active-high reset
//   btn_prev_raw  in   raw PREV button (asynchronous, bouncy, active-high)
//   btn_next_raw  in   raw NEXT button (asynchronous, bouncy, active-high)
//   song_done     in   1-cycle pulse, current track finished
//   prev          out  1-cycle pulse on a backward step
//   next          out  1-cycle pulse on a forward step (button or song_done)
//   track_idx     out  current track index, 0-based
//   trk_ones      out  BCD ones digit of track_idx+1
//   trk_tens      out  BCD tens digit of track_idx+1
// ---------------------------------------------------------------------------
module track_select_ctrl #(
    parameter int NUM_TRACKS      = 12,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_prev_raw,
    input  logic       btn_next_raw,
    input  logic       song_done,
    output logic       prev,
    output logic       next,
    output logic [6:0] track_idx,
    output logic [3:0] trk_ones,
    output logic [3:0] trk_tens
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Arming after reset needs a stable low that outlasts the two reset-zero
    // samples still sitting in the synchroniser, hence the +1.
    localparam int               ARM_W   = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(DEBOUNCE_CYCLES + 1);
    localparam logic [6:0]       IDX_MAX = 7'(NUM_TRACKS - 1);
    localparam logic [3:0]       NT_TENS = 4'(NUM_TRACKS / 10);
    localparam logic [3:0]       NT_ONES = 4'(NUM_TRACKS % 10);

    logic [1:0] raw;    // [0] = PREV, [1] = NEXT
    logic [1:0] press;

    assign raw = {btn_next_raw, btn_prev_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic             s1_q;
            logic             s2_q;
            logic             db_q;
            logic             db_prev_q;
            logic             armed_q;
            logic [CNT_W-1:0] cnt_q;
            logic [ARM_W-1:0] arm_cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_q      <= 1'b0;
                    s2_q      <= 1'b0;
                    db_q      <= 1'b0;
                    db_prev_q <= 1'b0;
                    armed_q   <= 1'b0;
                    cnt_q     <= '0;
                    arm_cnt_q <= '0;
                end else begin
                    s1_q      <= raw[gi];
                    s2_q      <= s1_q;
                    db_prev_q <= db_q;

                    if (s2_q == db_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        db_q  <= s2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end

                    // A rising debounced level only counts as a press if the
                    // button was seen released first: either a debounced
                    // 1->0, or a long enough stable low after reset. This
                    // keeps a button held through reset from stepping.
                    if (db_q) begin
                        armed_q   <= 1'b0;
                        arm_cnt_q <= '0;
                    end else if (db_prev_q) begin
                        armed_q   <= 1'b1;
                    end else if (!armed_q) begin
                        if (s2_q) begin
                            arm_cnt_q <= '0;
                        end else if (arm_cnt_q == ARM_MAX) begin
                            armed_q <= 1'b1;
                        end else begin
                            arm_cnt_q <= arm_cnt_q + 1'b1;
                        end
                    end
                end
            end

            assign press[gi] = db_q & ~db_prev_q & armed_q;
        end
    endgenerate

    logic       prev_q, prev_d;
    logic       next_q, next_d;
    logic [6:0] idx_q, idx_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    always_comb begin
        prev_d = 1'b0;
        next_d = 1'b0;
        idx_d  = idx_q;
        ones_d = ones_q;
        tens_d = tens_q;
        if (press[0] && press[1]) begin
            // Simultaneous presses cancel, and also swallow song_done.
        end else if (press[0]) begin
            prev_d = 1'b1;
            if (idx_q == 7'd0) begin
                idx_d  = IDX_MAX;
                tens_d = NT_TENS;
                ones_d = NT_ONES;
            end else begin
                idx_d = idx_q - 7'd1;
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end else if (press[1] || song_done) begin
            next_d = 1'b1;
            if (idx_q == IDX_MAX) begin
                idx_d  = 7'd0;
                tens_d = 4'd0;
                ones_d = 4'd1;
            end else begin
                idx_d = idx_q + 7'd1;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            next_q <= 1'b0;
            idx_q  <= 7'd0;
            ones_q <= 4'd1;
            tens_q <= 4'd0;
        end else begin
            prev_q <= prev_d;
            next_q <= next_d;
            idx_q  <= idx_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign prev      = prev_q;
    assign next      = next_q;
    assign track_idx = idx_q;
    assign trk_ones  = ones_q;
    assign trk_tens  = tens_q;

endmodule

// File: tb/tb_track_select_ctrl.sv
module tb_track_select_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_prev_raw = 1'b0;
    logic       btn_next_raw = 1'b0;
    logic       song_done = 1'b0;
    logic       prev;
    logic       next;
    logic [6:0] track_idx;
    logic [3:0] trk_ones;
    logic [3:0] trk_tens;

    int checks = 0;
    int errors = 0;

    // Pulse tallies, written only by the monitor below.
    int prev_total = 0;
    int next_total = 0;
    int both_total = 0;

    always #5 clk = ~clk;

    track_select_ctrl #(
        .NUM_TRACKS(12),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_prev_raw(btn_prev_raw),
        .btn_next_raw(btn_next_raw),
        .song_done(song_done),
        .prev(prev),
        .next(next),
        .track_idx(track_idx),
        .trk_ones(trk_ones),
        .trk_tens(trk_tens)
    );

    always @(posedge clk) begin
        #1;
        if (prev) prev_total++;
        if (next) next_total++;
        if (prev && next) both_total++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic press(input bit is_next);
        if (is_next) btn_next_raw = 1'b1; else btn_prev_raw = 1'b1;
        tick(10);
        if (is_next) btn_next_raw = 1'b0; else btn_prev_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        checks++;
        if (track_idx !== 7'd0 || trk_ones !== 4'd1 || trk_tens !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: idx=%0d tens=%0d ones=%0d, want 0 0 1", track_idx, trk_tens, trk_ones);
        end
        rst = 1'b0;
        tick(20);
        checks++;
        if (prev !== 1'b0 || next !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: prev=%b next=%b, want 0 0", prev, next);
        end
        checks++;
        if (track_idx !== 7'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d want 0", track_idx);
        end
        checks++;
        if (trk_tens !== 4'd0 || trk_ones !== 4'd1) begin
            errors++;
            $display("FAIL reset_digits: got %0d/%0d want 0/1", trk_tens, trk_ones);
        end
        $display("reset: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);
    endtask

    task automatic test_debounce_next;
        int n0;
        n0 = next_total;
        btn_next_raw = 1'b1; tick(1);
        btn_next_raw = 1'b0; tick(1);
        btn_next_raw = 1'b1; tick(1);
        btn_next_raw = 1'b0; tick(1);
        btn_next_raw = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (next !== (i == 7)) begin
                errors++;
                $display("FAIL debounce_pulse_cycle%0d: next=%b want %b", i, next, (i == 7));
            end
        end
        checks++;
        if (next_total - n0 != 1) begin
            errors++;
            $display("FAIL debounce_pulse_count: got %0d want 1", next_total - n0);
        end
        checks++;
        if (track_idx !== 7'd1 || trk_tens !== 4'd0 || trk_ones !== 4'd2) begin
            errors++;
            $display("FAIL debounce_state: idx=%0d digits=%0d/%0d want 1 0/2", track_idx, trk_tens, trk_ones);
        end
        btn_next_raw = 1'b0;
        tick(10);
        $display("debounce_next: idx=%0d digits=%0d/%0d pulses=%0d", track_idx, trk_tens, trk_ones, next_total - n0);
    endtask

    task automatic test_wrap;
        int p0;
        press(1'b0);   // back to 0
        p0 = prev_total;
        press(1'b0);   // wrap to 11
        checks++;
        if (prev_total - p0 != 1) begin
            errors++;
            $display("FAIL wrap_prev_pulse: got %0d want 1", prev_total - p0);
        end
        checks++;
        if (track_idx !== 7'd11 || trk_tens !== 4'd1 || trk_ones !== 4'd2) begin
            errors++;
            $display("FAIL wrap_back: idx=%0d digits=%0d/%0d want 11 1/2", track_idx, trk_tens, trk_ones);
        end
        $display("wrap_back: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);
        press(1'b1);
        checks++;
        if (track_idx !== 7'd0 || trk_tens !== 4'd0 || trk_ones !== 4'd1) begin
            errors++;
            $display("FAIL wrap_fwd: idx=%0d digits=%0d/%0d want 0 0/1", track_idx, trk_tens, trk_ones);
        end
        $display("wrap_fwd: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);
    endtask

    task automatic test_bcd_carry;
        for (int i = 0; i < 9; i++) press(1'b1);
        checks++;
        if (track_idx !== 7'd9 || trk_tens !== 4'd1 || trk_ones !== 4'd0) begin
            errors++;
            $display("FAIL bcd_carry: idx=%0d digits=%0d/%0d want 9 1/0", track_idx, trk_tens, trk_ones);
        end
        $display("bcd_carry: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);
        press(1'b0);
        checks++;
        if (track_idx !== 7'd8 || trk_tens !== 4'd0 || trk_ones !== 4'd9) begin
            errors++;
            $display("FAIL bcd_borrow: idx=%0d digits=%0d/%0d want 8 0/9", track_idx, trk_tens, trk_ones);
        end
        $display("bcd_borrow: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);
    endtask

    task automatic test_arbitration;
        int p0, n0;
        p0 = prev_total; n0 = next_total;
        btn_prev_raw = 1'b1; btn_next_raw = 1'b1;
        tick(10);
        btn_prev_raw = 1'b0; btn_next_raw = 1'b0;
        tick(10);
        checks++;
        if (prev_total != p0 || next_total != n0 || track_idx !== 7'd8) begin
            errors++;
            $display("FAIL both_pressed: prev+%0d next+%0d idx=%0d want 0 0 8",
                     prev_total - p0, next_total - n0, track_idx);
        end
        $display("both_pressed: idx=%0d", track_idx);

        n0 = next_total;
        song_done = 1'b1; tick(1);
        song_done = 1'b0; tick(2);
        checks++;
        if (next_total - n0 != 1 || track_idx !== 7'd9 || trk_tens !== 4'd1 || trk_ones !== 4'd0) begin
            errors++;
            $display("FAIL song_done: next+%0d idx=%0d digits=%0d/%0d want 1 9 1/0",
                     next_total - n0, track_idx, trk_tens, trk_ones);
        end
        $display("song_done: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);

        p0 = prev_total; n0 = next_total;
        btn_prev_raw = 1'b1;
        tick(6);                    // debounced level is now high: press request live
        song_done = 1'b1; tick(1);
        song_done = 1'b0; tick(4);
        btn_prev_raw = 1'b0;
        tick(10);
        checks++;
        if (prev_total - p0 != 1 || next_total != n0) begin
            errors++;
            $display("FAIL prev_vs_done_pulses: prev+%0d next+%0d want 1 0", prev_total - p0, next_total - n0);
        end
        checks++;
        if (track_idx !== 7'd8 || trk_tens !== 4'd0 || trk_ones !== 4'd9) begin
            errors++;
            $display("FAIL prev_vs_done_state: idx=%0d digits=%0d/%0d want 8 0/9", track_idx, trk_tens, trk_ones);
        end
        $display("prev_vs_done: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);
    endtask

    task automatic test_reset_mid_press;
        int n0;
        btn_next_raw = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        n0 = next_total;
        tick(20);
        checks++;
        if (next_total != n0) begin
            errors++;
            $display("FAIL held_through_reset: next+%0d want 0", next_total - n0);
        end
        checks++;
        if (track_idx !== 7'd0 || trk_tens !== 4'd0 || trk_ones !== 4'd1) begin
            errors++;
            $display("FAIL reset_mid_state: idx=%0d digits=%0d/%0d want 0 0/1", track_idx, trk_tens, trk_ones);
        end
        $display("held_through_reset: idx=%0d pulses=%0d", track_idx, next_total - n0);
        btn_next_raw = 1'b0;
        tick(10);
        n0 = next_total;
        press(1'b1);
        checks++;
        if (next_total - n0 != 1 || track_idx !== 7'd1 || trk_ones !== 4'd2) begin
            errors++;
            $display("FAIL repress_after_reset: next+%0d idx=%0d ones=%0d want 1 1 2",
                     next_total - n0, track_idx, trk_ones);
        end
        $display("repress_after_reset: idx=%0d digits=%0d/%0d", track_idx, trk_tens, trk_ones);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_debounce_next;
        test_wrap;
        test_bcd_carry;
        test_arbitration;
        test_reset_mid_press;
        checks++;
        if (both_total != 0) begin
            errors++;
            $display("FAIL pulses_exclusive: prev and next high together %0d times, want 0", both_total);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
